// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions raw, asynchronous, bouncing push-button pins for the stopwatch
//   controller. Each channel is synchronised into the clk domain and debounced.
//   It then yields a stable level plus single-cycle press/release pulses, so the
//   controller can act on clean events instead of raw pin edges.
//
// Parameters
//   N_BTN            number of independent button channels (>=1)
//   SYNC_STAGES      synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  consecutive clk cycles a new level must persist (>=1)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   btn_in       in   [N_BTN] raw button pins, active high, asynchronous
//   btn_level    out  [N_BTN] debounced level
//   btn_press    out  [N_BTN] one-cycle pulse on each debounced 0->1
//   btn_release  out  [N_BTN] one-cycle pulse on each debounced 1->0
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Terminal count: the candidate level is accepted on the edge where the
  // counter already shows DEBOUNCE_CYCLES-1 prior mismatching cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;

    // Only the final synchroniser stage is trusted downstream.
    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync    <= '0;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_in[gi]};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_s == r_level) begin
          // Any return to the stable level restarts the qualification window.
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level   <= w_s;
          r_cnt     <= '0;
          r_press   <= w_s;
          r_release <= ~w_s;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_level[gi]   = r_level;
    assign w_press[gi]   = r_press;
    assign w_release[gi] = r_release;
  end

  assign btn_level   = w_level;
  assign btn_press   = w_press;
  assign btn_release = w_release;

endmodule
